// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage and producer side of the IF->DQ interface.
//   Holds the PC and issues one-word req/ack reads to instruction memory.
//   Presents a single {instruction, PC} entry to the decode queue and holds it
//   until the queue accepts it. Handles branch redirects and the SYS flush.
//
// Ports
//   CLK          in   1   clock, all state on posedge
//   RESET        in   1   synchronous, active-high reset
//   SYS          in   1   syscall flush
//   REDIRECT     in   1   branch/jump taken; discard held entry, refetch
//   REDIRECT_PC  in   32  redirect target (bits [1:0] ignored)
//   STALL_IN_DQ  in   1   decode queue full; entry not accepted this edge
//   IMEM_REQ     out  1   memory read request
//   IMEM_ADDR    out  32  word address of the request (= pc)
//   IMEM_ACK     in   1   read completes this cycle
//   IMEM_RDATA   in   32  instruction word, valid with IMEM_ACK
//   Instr_OUT    out  32  instruction presented to the decode queue
//   Instr_PC_OUT out  32  PC of Instr_OUT
//   STALL_OUT_DQ out  1   1 = no valid entry presented
//   BUSY_SYS     out  1   1 while the SYS flush is in progress
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0040_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        SYS,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    input  logic        STALL_IN_DQ,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_ACK,
    input  logic [31:0] IMEM_RDATA,
    output logic [31:0] Instr_OUT,
    output logic [31:0] Instr_PC_OUT,
    output logic        STALL_OUT_DQ,
    output logic        BUSY_SYS
);

    localparam int              CNT_W    = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic {
        RUN      = 1'b0,
        SYS_WAIT = 1'b1
    } state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt_p0, cnt_n;
    logic [31:0]       pc_p0, pc_n;
    logic              vld_p0, vld_n;
    logic [31:0]       instr_p0, instr_n;
    logic [31:0]       ipc_p0, ipc_n;
    logic              req;

    // A request is only raised when the output slot is free or is being
    // drained this same edge, so at most one read is ever outstanding and
    // a returning word always has somewhere to land.
    always_comb begin
        req = ~RESET & (state == RUN) & ~REDIRECT & ~SYS & (~vld_p0 | ~STALL_IN_DQ);
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt_p0;
        pc_n    = pc_p0;
        vld_n   = vld_p0;
        instr_n = instr_p0;
        ipc_n   = ipc_p0;
        if (SYS) begin
            // Also taken while already flushing: reloads the idle count.
            state_n = SYS_WAIT;
            cnt_n   = CNT_LOAD;
            vld_n   = 1'b0;
            pc_n    = EXC_VECTOR;
        end else if (state == SYS_WAIT) begin
            // REDIRECT is deliberately ignored while flushing.
            if (cnt_p0 == '0) begin
                state_n = RUN;
            end else begin
                cnt_n = cnt_p0 - 1'b1;
            end
        end else if (REDIRECT) begin
            // Any ACK arriving this cycle belongs to the wrong path and is dropped.
            vld_n = 1'b0;
            pc_n  = {REDIRECT_PC[31:2], 2'b00};
        end else if (req && IMEM_ACK) begin
            // Replaces the held entry; if the DQ took it this edge that
            // gives one instruction per cycle.
            instr_n = IMEM_RDATA;
            ipc_n   = pc_p0;
            vld_n   = 1'b1;
            pc_n    = pc_p0 + 32'd4;
        end else if (vld_p0 && !STALL_IN_DQ) begin
            vld_n = 1'b0;
        end
    end

    // ---- stage p0: PC, flush FSM and output entry register ----
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= RUN;
            cnt_p0   <= '0;
            pc_p0    <= RESET_PC;
            vld_p0   <= 1'b0;
            instr_p0 <= '0;
            ipc_p0   <= '0;
        end else begin
            state    <= state_n;
            cnt_p0   <= cnt_n;
            pc_p0    <= pc_n;
            vld_p0   <= vld_n;
            instr_p0 <= instr_n;
            ipc_p0   <= ipc_n;
        end
    end

    always_comb begin
        IMEM_REQ     = req;
        IMEM_ADDR    = pc_p0;
        Instr_OUT    = instr_p0;
        Instr_PC_OUT = ipc_p0;
        STALL_OUT_DQ = ~vld_p0;
        BUSY_SYS     = (state == SYS_WAIT);
    end

endmodule
